// File: rtl/moving_avg_filter_mc.sv
// ---------------------------------------------------------------------------
// moving_avg_filter_mc
// Boxcar moving-average filter with a run-time selectable power-of-two window
// (2**k samples, k = 0..SIZE_MAX). It smooths phase-error samples for the
// MMCM servo loop. Samples go into a circular buffer. A running sum adds each
// new sample and subtracts the one that leaves the window. The sum is wide
// enough that it never wraps.
//
// Parameters:
//   WIDTH     signed sample width
//   SIZE_MAX  log2 of the largest window; buffer depth is 2**SIZE_MAX
//   ROUND     0: truncate toward -inf; 1: round half up
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset_in    synchronous, active-high reset
//   CE          sample enable; data_in is accepted while high
//   win_sel     requested k; values above SIZE_MAX clamp to SIZE_MAX
//   data_in     input sample (signed)
//   data_out    window average (signed); holds between strobes
//   data_valid  one-cycle strobe: data_out updated and the window is full
//   filled      level: at least 2**k samples accepted since the last restart
//   k_active    window exponent currently in use
// ---------------------------------------------------------------------------
module moving_avg_filter_mc #(
   parameter  int WIDTH    = 16,
   parameter  int SIZE_MAX = 5,
   parameter  bit ROUND    = 1'b0,
   localparam int KW       = $clog2(SIZE_MAX + 1)
) (
   input  logic                    clk,
   input  logic                    reset_in,
   input  logic                    CE,
   input  logic [KW-1:0]           win_sel,
   input  logic signed [WIDTH-1:0] data_in,
   output logic signed [WIDTH-1:0] data_out,
   output logic                    data_valid,
   output logic                    filled,
   output logic [KW-1:0]           k_active
);

   localparam int DEPTH = 2 ** SIZE_MAX;
   localparam int ACC_W = WIDTH + SIZE_MAX;

   logic signed [WIDTH-1:0] r_mem [DEPTH];
   logic [SIZE_MAX-1:0]     r_wr_ptr;
   logic [SIZE_MAX:0]       r_fill_cnt;
   logic signed [ACC_W-1:0] r_accum;
   logic                    r_upd;        // an accept happened on the previous edge
   logic [KW-1:0]           r_k_active;
   logic signed [WIDTH-1:0] r_data_out;
   logic                    r_data_valid;
   logic                    r_filled;

   logic [KW-1:0]           w_k_req;
   logic                    w_restart;
   logic                    w_accept;
   logic [SIZE_MAX:0]       w_win;
   logic                    w_full;
   logic [SIZE_MAX-1:0]     w_rd_addr;
   logic signed [WIDTH-1:0] w_old_raw;
   logic signed [ACC_W-1:0] w_old_x;
   logic signed [ACC_W-1:0] w_din_x;
   logic [ACC_W:0]          w_rnd;
   logic signed [ACC_W:0]   w_sum;
   logic signed [WIDTH-1:0] w_avg;

   assign w_k_req   = (win_sel > KW'(SIZE_MAX)) ? KW'(SIZE_MAX) : win_sel;
   assign w_restart = (w_k_req != r_k_active);
   assign w_accept  = CE && !w_restart;

   assign w_win  = (SIZE_MAX + 1)'(1) << r_k_active;
   assign w_full = (r_fill_cnt == w_win);

   // For the largest window the low bits of w_win are zero, so the read
   // address equals the write address. The asynchronous read then returns
   // the oldest entry, before it is overwritten.
   assign w_rd_addr = r_wr_ptr - w_win[SIZE_MAX-1:0];
   assign w_old_raw = r_mem[w_rd_addr];

   // While filling, nothing has left the window yet. Stale RAM contents must
   // not be subtracted.
   assign w_old_x = w_full ? {{SIZE_MAX{w_old_raw[WIDTH-1]}}, w_old_raw} : '0;
   assign w_din_x = {{SIZE_MAX{data_in[WIDTH-1]}}, data_in};

   // Half an LSB of the shifted result is w_win/2. It is zero for k=0, so a
   // window of one sample passes through without rounding.
   assign w_rnd = ROUND ? (ACC_W + 1)'(w_win >> 1) : '0;
   assign w_sum = {r_accum[ACC_W-1], r_accum} + w_rnd;
   // The mean of WIDTH-bit values always fits in WIDTH bits, so the
   // truncation is exact.
   assign w_avg = WIDTH'(w_sum >>> r_k_active);

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before the edge. The output stage depends on this
   // because it reads r_accum and r_fill_cnt as left by the previous accept.
   always_ff @(posedge clk) begin
      if (reset_in) begin
         r_wr_ptr     <= '0;
         r_fill_cnt   <= '0;
         r_accum      <= '0;
         r_upd        <= 1'b0;
         r_k_active   <= w_k_req;
         r_data_out   <= '0;
         r_data_valid <= 1'b0;
         r_filled     <= 1'b0;
      end else if (w_restart) begin
         // New window size: discard the running sum and any in-flight result.
         // wr_ptr keeps moving, and data_out holds its last value.
         r_k_active   <= w_k_req;
         r_fill_cnt   <= '0;
         r_accum      <= '0;
         r_upd        <= 1'b0;
         r_data_valid <= 1'b0;
         r_filled     <= 1'b0;
      end else begin
         r_upd <= CE;
         if (CE) begin
            r_wr_ptr <= r_wr_ptr + SIZE_MAX'(1);
            r_accum  <= r_accum + w_din_x - w_old_x;
            if (!w_full) begin
               r_fill_cnt <= r_fill_cnt + (SIZE_MAX + 1)'(1);
            end
         end
         // Output stage, one cycle behind the accept that it reports.
         if (r_upd) begin
            r_data_out   <= w_avg;
            r_data_valid <= w_full;
            r_filled     <= w_full;
         end else begin
            r_data_valid <= 1'b0;
         end
      end
   end

   // NOTE: the sample buffer has no reset. Each entry is read only after the
   // current fill has written it, so clearing the RAM would add reset fan-out
   // and would stop the tools from mapping it to distributed RAM.
   always_ff @(posedge clk) begin
      if (!reset_in && w_accept) begin
         r_mem[r_wr_ptr] <= data_in;
      end
   end

   assign data_out   = r_data_out;
   assign data_valid = r_data_valid;
   assign filled     = r_filled;
   assign k_active   = r_k_active;

endmodule

// File: tb/tb_moving_avg_filter_mc.sv
// ---------------------------------------------------------------------------
// tb_moving_avg_filter_mc
// Self-checking bench for moving_avg_filter_mc with WIDTH=16 and SIZE_MAX=5.
// Two instances, one truncating and one rounding, share the same stimulus.
// The reference model keeps a queue of the samples inside the current window
// and averages them with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_moving_avg_filter_mc;

   localparam int WIDTH    = 16;
   localparam int SIZE_MAX = 5;
   localparam int KW       = 3;

   logic                    clk = 1'b0;
   logic                    reset_in = 1'b1;
   logic                    CE = 1'b0;
   logic [KW-1:0]           win_sel = '0;
   logic signed [WIDTH-1:0] data_in = '0;

   logic signed [WIDTH-1:0] out0, out1;
   logic                    valid0, valid1, filled0, filled1;
   logic [KW-1:0]           k0, k1;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   moving_avg_filter_mc #(.WIDTH(WIDTH), .SIZE_MAX(SIZE_MAX), .ROUND(1'b0)) u_dut_t (
      .clk(clk), .reset_in(reset_in), .CE(CE), .win_sel(win_sel), .data_in(data_in),
      .data_out(out0), .data_valid(valid0), .filled(filled0), .k_active(k0));

   moving_avg_filter_mc #(.WIDTH(WIDTH), .SIZE_MAX(SIZE_MAX), .ROUND(1'b1)) u_dut_r (
      .clk(clk), .reset_in(reset_in), .CE(CE), .win_sel(win_sel), .data_in(data_in),
      .data_out(out1), .data_valid(valid1), .filled(filled1), .k_active(k1));

   // Reference model state.
   longint                  m_q[$];
   int                      m_k = 0;
   logic signed [WIDTH-1:0] m_out0 = '0, m_out1 = '0;
   bit                      m_valid = 0, m_filled = 0;
   bit                      m_pend = 0, m_pend_full = 0;
   longint                  m_pend_sum = 0;

   task automatic check(input string nm, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Applies one clock edge to the model: reset, then window change, then
   // the output for the previous accept, then the new sample.
   task automatic model_tick(input logic rst, input logic ce, input logic [KW-1:0] ws,
                             input logic signed [WIDTH-1:0] din);
      int kr;
      kr = (int'(ws) > SIZE_MAX) ? SIZE_MAX : int'(ws);
      if (rst) begin
         m_q.delete(); m_k = kr; m_out0 = '0; m_out1 = '0;
         m_valid = 0; m_filled = 0; m_pend = 0;
      end else if (kr != m_k) begin
         m_q.delete(); m_k = kr; m_valid = 0; m_filled = 0; m_pend = 0;
      end else begin
         if (m_pend) begin
            m_out0   = WIDTH'(m_pend_sum >>> m_k);
            m_out1   = WIDTH'((m_pend_sum + ((longint'(1) << m_k) >> 1)) >>> m_k);
            m_valid  = m_pend_full;
            m_filled = m_pend_full;
         end else begin
            m_valid = 0;
         end
         m_pend = ce;
         if (ce) begin
            m_q.push_back(longint'(din));
            if (m_q.size() > (1 << m_k)) void'(m_q.pop_front());
            m_pend_sum = 0;
            foreach (m_q[i]) m_pend_sum += m_q[i];
            m_pend_full = (m_q.size() == (1 << m_k));
         end
      end
   endtask

   // Drives one cycle, advances the model, then samples 1 ns after the edge.
   task automatic step(input logic rst, input logic ce, input logic [KW-1:0] ws,
                       input logic signed [WIDTH-1:0] din);
      reset_in = rst; CE = ce; win_sel = ws; data_in = din;
      @(posedge clk);
      model_tick(rst, ce, ws, din);
      #1;
      check("k_active",     k0,      m_k);
      check("data_valid_t", valid0,  m_valid);
      check("filled_t",     filled0, m_filled);
      check("data_out_t",   out0,    m_out0);
      check("data_valid_r", valid1,  m_valid);
      check("filled_r",     filled1, m_filled);
      check("data_out_r",   out1,    m_out1);
   endtask

   typedef struct {
      logic                    rst;
      logic                    ce;
      logic [KW-1:0]           ws;
      logic signed [WIDTH-1:0] din;
      logic                    exp_valid;
      logic signed [WIDTH-1:0] exp_out_t;
      logic signed [WIDTH-1:0] exp_out_r;
   } vec_t;

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t tbl[19];
      logic signed [WIDTH-1:0] got[$];
      logic [KW-1:0] ws;

      // Expected values are derived by hand.
      // Rows 0-4: k=1 with samples -3, -4 (truncate gives -4, round gives -3).
      // Rows 5-9: k=0 passes the sample through one cycle later.
      // Rows 10-18: k=2 with constant 100, valid one cycle after the 4th accept.
      tbl[0]  = '{1'b1, 1'b0, 3'd1, 16'sd0,    1'b0, 16'sd0,   16'sd0};
      tbl[1]  = '{1'b0, 1'b1, 3'd1, -16'sd3,   1'b0, 16'sd0,   16'sd0};
      tbl[2]  = '{1'b0, 1'b1, 3'd1, -16'sd4,   1'b0, -16'sd2,  -16'sd1};
      tbl[3]  = '{1'b0, 1'b0, 3'd1, 16'sd0,    1'b1, -16'sd4,  -16'sd3};
      tbl[4]  = '{1'b0, 1'b0, 3'd1, 16'sd0,    1'b0, -16'sd4,  -16'sd3};
      tbl[5]  = '{1'b0, 1'b1, 3'd0, 16'sd7,    1'b0, -16'sd4,  -16'sd3};
      tbl[6]  = '{1'b0, 1'b1, 3'd0, 16'sd7,    1'b0, -16'sd4,  -16'sd3};
      tbl[7]  = '{1'b0, 1'b0, 3'd0, 16'sd0,    1'b1, 16'sd7,   16'sd7};
      tbl[8]  = '{1'b0, 1'b1, 3'd0, -16'sd9,   1'b0, 16'sd7,   16'sd7};
      tbl[9]  = '{1'b0, 1'b0, 3'd0, 16'sd0,    1'b1, -16'sd9,  -16'sd9};
      tbl[10] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b0, -16'sd9,  -16'sd9};
      tbl[11] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b0, -16'sd9,  -16'sd9};
      tbl[12] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b0, 16'sd25,  16'sd25};
      tbl[13] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b0, 16'sd50,  16'sd50};
      tbl[14] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b0, 16'sd75,  16'sd75};
      tbl[15] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b1, 16'sd100, 16'sd100};
      tbl[16] = '{1'b0, 1'b1, 3'd2, 16'sd100,  1'b1, 16'sd100, 16'sd100};
      tbl[17] = '{1'b0, 1'b0, 3'd2, 16'sd0,    1'b1, 16'sd100, 16'sd100};
      tbl[18] = '{1'b0, 1'b0, 3'd2, 16'sd0,    1'b0, 16'sd100, 16'sd100};

      for (int i = 0; i < 19; i++) begin
         step(tbl[i].rst, tbl[i].ce, tbl[i].ws, tbl[i].din);
         check($sformatf("tbl%0d_valid", i), valid0, tbl[i].exp_valid);
         check($sformatf("tbl%0d_out_t", i), out0,   tbl[i].exp_out_t);
         check($sformatf("tbl%0d_out_r", i), out1,   tbl[i].exp_out_r);
      end

      // k=3: eight zeros then constant 80 gives 0, 10, 20, ... 80, then 80.
      step(1'b0, 1'b0, 3'd3, 16'sd0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd3, 16'sd0);
      for (int j = 1; j <= 11; j++) begin
         step(1'b0, 1'b1, 3'd3, 16'sd80);
         check("ramp80_valid", valid0, 1'b1);
         check("ramp80_out", out0, ((j - 1) * 10 > 80) ? 80 : (j - 1) * 10);
      end

      // k=5 at the extremes: 32x 32767, then 32x -32768. The sum must not wrap.
      step(1'b0, 1'b0, 3'd5, 16'sd0);
      for (int i = 0; i < 33; i++) step(1'b0, 1'b1, 3'd5, 16'sd32767);
      check("max_out", out0, 32767);
      for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 3'd5, -16'sd32768);
      step(1'b0, 1'b0, 3'd5, 16'sd0);
      check("min_out", out0, -32768);

      // k=2 ramp 1..8 with two idle cycles after each accept. The result must
      // match a contiguous run: 2,3,4,5,6.
      step(1'b0, 1'b0, 3'd2, 16'sd0);
      for (int s = 1; s <= 8; s++) begin
         step(1'b0, 1'b1, 3'd2, WIDTH'(s));
         if (valid0) got.push_back(out0);
         for (int g = 0; g < 2; g++) begin
            step(1'b0, 1'b0, 3'd2, 16'sd0);
            if (valid0) got.push_back(out0);
         end
      end
      check("gap_count", got.size(), 5);
      for (int i = 0; i < got.size() && i < 5; i++)
         check($sformatf("gap_out%0d", i), got[i], i + 2);

      // Change win_sel from 2 to 4 mid-run with CE high: the sample is dropped,
      // filled clears, and the next valid comes after 16 accepts.
      step(1'b0, 1'b1, 3'd4, 16'sd999);
      check("restart_filled", filled0, 1'b0);
      check("restart_valid", valid0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         step(1'b0, 1'b1, 3'd4, WIDTH'(i));
         check("refill_novalid", valid0, 1'b0);
      end
      step(1'b0, 1'b0, 3'd4, 16'sd0);
      check("refill_valid", valid0, 1'b1);
      check("refill_out", out0, 8);   // sum 1..16 = 136, 136>>>4 = 8

      // Pulse reset mid-fill, then refill from zero.
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd1, 16'sd50);
      step(1'b1, 1'b0, 3'd1, 16'sd0);
      check("rst_filled", filled0, 1'b0);
      check("rst_out", out0, 0);
      step(1'b0, 1'b1, 3'd1, 16'sd20);
      step(1'b0, 1'b1, 3'd1, 16'sd40);
      step(1'b0, 1'b0, 3'd1, 16'sd0);
      check("rst_refill", out0, 30);

      // Random traffic, including clamped win_sel values and rare resets.
      ws = 3'd2;
      for (int c = 0; c < 3000; c++) begin
         logic signed [WIDTH-1:0] d;
         if ($urandom_range(0, 63) == 0) ws = KW'($urandom_range(0, 7));
         case ($urandom_range(0, 7))
            0:       d = 16'sh7fff;
            1:       d = 16'sh8000;
            default: d = WIDTH'($urandom);
         endcase
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), ws, d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
